// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision accumulator and its adder:
// field widths, special encodings, opcodes and the accumulator state type.
package fp_pkg;

  localparam int unsigned FP_DATA_WIDTH = 32;
  localparam int unsigned FP_MENT_WIDTH = 23;
  localparam int unsigned FP_EXPO_WIDTH = 8;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
  localparam logic [7:0]  FP_EXP_ONES = 8'hFF;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    EXEC,
    DONE
  } acc_state_t;

endpackage

// File: rtl/floating_point_addition.sv
// Combinational single-precision adder/subtractor. Subnormal inputs are
// flushed to zero; results round to nearest-even on the retained guard bits.
module floating_point_addition
  import fp_pkg::*;
(
  input  logic [31:0] floating1_in,
  input  logic [31:0] floating2_in,
  input  logic        opcode_in,
  output logic [31:0] floating_addition_out
);

  logic        sa, sb, swap, found, round_up;
  logic [7:0]  ea, eb, big_e, small_e, ediff;
  logic [22:0] ma, mb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, big_s, small_s;
  logic [26:0] big_m, small_m, small_sh;
  logic [27:0] mag, norm;
  logic [4:0]  lz;
  logic [8:0]  exp_base, exp_norm, exp_fin;
  logic [24:0] rounded;
  logic [22:0] frac;

  // Align, add/subtract magnitudes, normalise, round, then patch specials.
  always_comb begin
    sa = floating1_in[31];
    ea = floating1_in[30:23];
    ma = floating1_in[22:0];
    sb = floating2_in[31] ^ (opcode_in == OP_SUB);
    eb = floating2_in[30:23];
    mb = floating2_in[22:0];

    a_nan  = (ea == FP_EXP_ONES) && (ma != '0);
    b_nan  = (eb == FP_EXP_ONES) && (mb != '0);
    a_inf  = (ea == FP_EXP_ONES) && (ma == '0);
    b_inf  = (eb == FP_EXP_ONES) && (mb == '0);
    a_zero = (ea == '0);
    b_zero = (eb == '0);

    swap    = {eb, mb} > {ea, ma};
    big_s   = swap ? sb : sa;
    small_s = swap ? sa : sb;
    big_e   = swap ? eb : ea;
    small_e = swap ? ea : eb;
    big_m   = {1'b1, (swap ? mb : ma), 3'b000};
    small_m = {1'b1, (swap ? ma : mb), 3'b000};

    ediff    = big_e - small_e;
    small_sh = (ediff > 8'd26) ? '0 : (small_m >> ediff);

    if (big_s == small_s) mag = {1'b0, big_m} + {1'b0, small_sh};
    else                  mag = {1'b0, big_m} - {1'b0, small_sh};

    lz    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 28; i++) begin
      if (!found && mag[27-i]) begin
        lz    = 5'(i);
        found = 1'b1;
      end
    end

    norm     = mag << lz;
    exp_base = {1'b0, big_e} + 9'd1;
    exp_norm = exp_base - {4'b0000, lz};

    round_up = norm[3] & (norm[2] | norm[1] | norm[0] | norm[4]);
    rounded  = {1'b0, norm[27:4]} + {24'b0, round_up};
    frac     = rounded[24] ? rounded[23:1] : rounded[22:0];
    exp_fin  = exp_norm + {8'b0, rounded[24]};

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
      floating_addition_out = FP_QNAN;
    else if (a_inf)
      floating_addition_out = floating1_in;
    else if (b_inf)
      floating_addition_out = {sb, FP_EXP_ONES, 23'b0};
    else if (a_zero && b_zero)
      floating_addition_out = {sa & sb, 31'b0};
    else if (a_zero)
      floating_addition_out = {sb, eb, mb};
    else if (b_zero)
      floating_addition_out = floating1_in;
    else if ((mag == '0) || (exp_base <= {4'b0000, lz}))
      floating_addition_out = FP_POS_ZERO;
    else if (exp_fin >= 9'd255)
      floating_addition_out = {big_s, FP_EXP_ONES, 23'b0};
    else
      floating_addition_out = {big_s, exp_fin[7:0], frac};
  end

endmodule

// File: rtl/fp_class_detect.sv
// NaN / infinity decode of an IEEE-754 exponent and mantissa field pair.
module fp_class_detect #(
  parameter int unsigned EXPO_WIDTH = 8,
  parameter int unsigned MENT_WIDTH = 23
) (
  input  logic [EXPO_WIDTH-1:0] expo,
  input  logic [MENT_WIDTH-1:0] ment,
  output logic                  is_nan,
  output logic                  is_inf
);

  // Exponent all-ones marks a special value; the mantissa picks NaN or Inf.
  always_comb begin
    is_nan = (&expo) && (|ment);
    is_inf = (&expo) && !(|ment);
  end

endmodule

// File: rtl/floating_point_accumulator.sv
// Sequential wrapper around an external combinational FP adder: accepts a
// valid/ready operand stream, folds each operand into a running sum and
// presents the final sum, operand count and exception flags.
// Optional: define FPACC_EXCEPTION_EN for sticky NaN/Inf flags.
module floating_point_accumulator
  import fp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MENT_WIDTH = 23,
  parameter int unsigned EXPO_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_op_in,
  input  logic                  data_last_in,
  input  logic                  data_valid_in,
  output logic                  data_ready_out,
  output logic [DATA_WIDTH-1:0] add_a_out,
  output logic [DATA_WIDTH-1:0] add_b_out,
  output logic                  add_op_out,
  input  logic [DATA_WIDTH-1:0] add_result_in,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic [CNT_WIDTH-1:0]  result_count_out,
  output logic                  result_valid_out,
  input  logic                  result_ready_in,
  output logic [1:0]            exc_flags_out
);

  localparam logic [DATA_WIDTH-1:0] POS_ZERO =
    DATA_WIDTH'({1'b0, {EXPO_WIDTH{1'b0}}, {MENT_WIDTH{1'b0}}});

  acc_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] sum_q, add_a_q, opnd_q;
  logic                  op_q, last_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  accept;

  assign accept = data_valid_in & data_ready_out;

  // State register; reset outranks start.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: start aborts from anywhere into ACCEPT.
  always_comb begin
    state_d = state_q;
    if (start_in) begin
      state_d = ACCEPT;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ACCEPT:  if (accept) state_d = EXEC;
        EXEC:    state_d = last_q ? DONE : ACCEPT;
        DONE:    if (result_ready_in) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake outputs; a start in the same cycle blocks operand acceptance.
  always_comb begin
    data_ready_out   = (state_q == ACCEPT) && !start_in;
    result_valid_out = (state_q == DONE);
  end

  // Adder operands are captured on accept so they stay put outside EXEC;
  // the sum and count update at the end of the single EXEC cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sum_q   <= '0;
      add_a_q <= '0;
      opnd_q  <= '0;
      op_q    <= OP_ADD;
      last_q  <= 1'b0;
      count_q <= '0;
    end else if (start_in) begin
      sum_q   <= POS_ZERO;
      count_q <= '0;
    end else begin
      if (accept) begin
        add_a_q <= sum_q;
        opnd_q  <= data_in;
        op_q    <= data_op_in;
        last_q  <= data_last_in;
      end
      if (state_q == EXEC) begin
        sum_q <= add_result_in;
        if (count_q != '1) count_q <= count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign add_a_out        = add_a_q;
  assign add_b_out        = opnd_q;
  assign add_op_out       = op_q;
  assign result_out       = sum_q;
  assign result_count_out = count_q;

`ifdef FPACC_EXCEPTION_EN
  logic       res_nan, res_inf;
  logic [1:0] flags_q;

  fp_class_detect #(
    .EXPO_WIDTH(EXPO_WIDTH),
    .MENT_WIDTH(MENT_WIDTH)
  ) u_class (
    .expo  (add_result_in[MENT_WIDTH +: EXPO_WIDTH]),
    .ment  (add_result_in[MENT_WIDTH-1:0]),
    .is_nan(res_nan),
    .is_inf(res_inf)
  );

  // Sticky flags accumulate on every EXEC capture until start or reset.
  always_ff @(posedge clk_in) begin
    if (rst_in || start_in)    flags_q <= '0;
    else if (state_q == EXEC)  flags_q <= flags_q | {res_inf, res_nan};
  end

  assign exc_flags_out = flags_q;
`else
  assign exc_flags_out = '0;
`endif

endmodule

// File: tb/tb_floating_point_accumulator.sv
// Directed self-checking bench for floating_point_accumulator, paired with
// floating_point_addition on the add_* ports.
module tb_floating_point_accumulator;

  localparam int unsigned CW = 4;

`ifdef FPACC_EXCEPTION_EN
  localparam logic [1:0] INF_FLAGS = 2'b10;
`else
  localparam logic [1:0] INF_FLAGS = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   data = '0;
  logic          data_op = 1'b0;
  logic          data_last = 1'b0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic [31:0]   add_a, add_b, add_res;
  logic          add_op;
  logic [31:0]   result;
  logic [CW-1:0] result_count;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [1:0]    exc_flags;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  floating_point_accumulator #(
    .DATA_WIDTH(32),
    .MENT_WIDTH(23),
    .EXPO_WIDTH(8),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .start_in        (start),
    .data_in         (data),
    .data_op_in      (data_op),
    .data_last_in    (data_last),
    .data_valid_in   (data_valid),
    .data_ready_out  (data_ready),
    .add_a_out       (add_a),
    .add_b_out       (add_b),
    .add_op_out      (add_op),
    .add_result_in   (add_res),
    .result_out      (result),
    .result_count_out(result_count),
    .result_valid_out(result_valid),
    .result_ready_in (result_ready),
    .exc_flags_out   (exc_flags)
  );

  floating_point_addition adder (
    .floating1_in         (add_a),
    .floating2_in         (add_b),
    .opcode_in            (add_op),
    .floating_addition_out(add_res)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic ack();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  // Present one operand and hold it until the handshake edge, bounded.
  task automatic send(input logic [31:0] d, input logic op, input logic last);
    bit done = 1'b0;
    data       = d;
    data_op    = op;
    data_last  = last;
    data_valid = 1'b1;
    #1;
    for (int i = 0; i < 10 && !done; i++) begin
      if (data_ready) done = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    data_last  = 1'b0;
    if (!done) begin
      total++;
      $display("FAIL send_timeout data_ready=%b required 1", data_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if ({result, result_count, result_valid, data_ready, exc_flags} !== '0)
      $display("FAIL reset_outputs got res=%h cnt=%h v=%b rdy=%b fl=%b required 0",
               result, result_count, result_valid, data_ready, exc_flags);
    else passed++;
    tick();
    total++;
    if (data_ready !== 1'b0 || result_valid !== 1'b0)
      $display("FAIL reset_idle got rdy=%b v=%b required 0 0", data_ready, result_valid);
    else passed++;
  endtask

  task automatic test_add();
    do_start();
    send(32'h3F80_0000, 1'b0, 1'b0);
    send(32'h4000_0000, 1'b0, 1'b1);
    total++;
    if (result_valid !== 1'b0 || add_a !== 32'h3F80_0000 || add_b !== 32'h4000_0000 || add_op !== 1'b0)
      $display("FAIL add_exec got v=%b a=%h b=%h op=%b required 0 3f800000 40000000 0",
               result_valid, add_a, add_b, add_op);
    else passed++;
    tick();
    total++;
    if (result_valid !== 1'b1 || result !== 32'h4040_0000 || result_count !== CW'(2))
      $display("FAIL add_result got v=%b res=%h cnt=%0d required 1 40400000 2",
               result_valid, result, result_count);
    else passed++;
    total++;
    if (exc_flags !== 2'b00 || add_b !== 32'h4000_0000)
      $display("FAIL add_hold got fl=%b b=%h required 00 40000000", exc_flags, add_b);
    else passed++;
    ack();
    total++;
    if (result_valid !== 1'b0)
      $display("FAIL add_ack got v=%b required 0", result_valid);
    else passed++;
  endtask

  task automatic test_sub();
    do_start();
    send(32'h40A0_0000, 1'b0, 1'b0);
    send(32'h4000_0000, 1'b1, 1'b1);
    total++;
    if (add_op !== 1'b1 || add_a !== 32'h40A0_0000)
      $display("FAIL sub_exec got op=%b a=%h required 1 40a00000", add_op, add_a);
    else passed++;
    tick();
    total++;
    if (result_valid !== 1'b1 || result !== 32'h4040_0000 || result_count !== CW'(2))
      $display("FAIL sub_result got v=%b res=%h cnt=%0d required 1 40400000 2",
               result_valid, result, result_count);
    else passed++;
    ack();
  endtask

  task automatic test_backpressure();
    do_start();
    send(32'h3F80_0000, 1'b0, 1'b0);
    send(32'h4000_0000, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (result_valid !== 1'b1 || result !== 32'h4040_0000 ||
          result_count !== CW'(2) || data_ready !== 1'b0)
        $display("FAIL hold_%0d got v=%b res=%h cnt=%0d rdy=%b required 1 40400000 2 0",
                 i, result_valid, result, result_count, data_ready);
      else passed++;
      tick();
    end
    ack();
    tick();
    total++;
    if (result_valid !== 1'b0 || data_ready !== 1'b0)
      $display("FAIL hold_idle got v=%b rdy=%b required 0 0", result_valid, data_ready);
    else passed++;
  endtask

  task automatic test_abort();
    do_start();
    send(32'h3F80_0000, 1'b0, 1'b0);
    send(32'h4000_0000, 1'b0, 1'b0);
    tick();
    total++;
    if (result_count !== CW'(2) || result !== 32'h4040_0000)
      $display("FAIL abort_pre got cnt=%0d res=%h required 2 40400000", result_count, result);
    else passed++;
    do_start();
    total++;
    if (result_count !== CW'(0) || result !== 32'h0)
      $display("FAIL abort_clear got cnt=%0d res=%h required 0 00000000", result_count, result);
    else passed++;
    // start and valid together: the operand must be refused
    start      = 1'b1;
    data       = 32'h4000_0000;
    data_last  = 1'b1;
    data_valid = 1'b1;
    #1;
    total++;
    if (data_ready !== 1'b0)
      $display("FAIL collide_ready got %b required 0", data_ready);
    else passed++;
    @(posedge clk);
    #1;
    start      = 1'b0;
    data_valid = 1'b0;
    data_last  = 1'b0;
    send(32'h3F80_0000, 1'b0, 1'b1);
    tick();
    total++;
    if (result_valid !== 1'b1 || result !== 32'h3F80_0000 || result_count !== CW'(1))
      $display("FAIL abort_result got v=%b res=%h cnt=%0d required 1 3f800000 1",
               result_valid, result, result_count);
    else passed++;
    do_start();
    total++;
    if (result_valid !== 1'b0 || result_count !== CW'(0))
      $display("FAIL abort_drop got v=%b cnt=%0d required 0 0", result_valid, result_count);
    else passed++;
  endtask

  task automatic test_reset_exec();
    do_start();
    send(32'h3F80_0000, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({result, result_count, result_valid, data_ready, add_a, add_b, add_op, exc_flags} !== '0)
      $display("FAIL rst_exec got res=%h cnt=%0d v=%b rdy=%b a=%h b=%h op=%b required all 0",
               result, result_count, result_valid, data_ready, add_a, add_b, add_op);
    else passed++;
    data       = 32'h4000_0000;
    data_last  = 1'b1;
    data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (result_valid !== 1'b0 || data_ready !== 1'b0)
        $display("FAIL rst_quiet_%0d got v=%b rdy=%b required 0 0", i, result_valid, data_ready);
      else passed++;
    end
    data_valid = 1'b0;
    data_last  = 1'b0;
    // fresh accumulation of a single subtracted operand: 0 - 2.0
    do_start();
    send(32'h4000_0000, 1'b1, 1'b1);
    tick();
    total++;
    if (result_valid !== 1'b1 || result !== 32'hC000_0000 || result_count !== CW'(1))
      $display("FAIL single_sub got v=%b res=%h cnt=%0d required 1 c0000000 1",
               result_valid, result, result_count);
    else passed++;
    ack();
  endtask

  task automatic test_saturate();
    do_start();
    for (int i = 0; i < 17; i++) send(32'h3F80_0000, 1'b0, (i == 16));
    tick();
    total++;
    if (result_valid !== 1'b1 || result !== 32'h4188_0000 || result_count !== '1)
      $display("FAIL saturate got v=%b res=%h cnt=%0d required 1 41880000 15",
               result_valid, result, result_count);
    else passed++;
    ack();
  endtask

  task automatic test_exception();
    do_start();
    send(32'h7F80_0000, 1'b0, 1'b1);
    tick();
    total++;
    if (result_valid !== 1'b1 || result !== 32'h7F80_0000 || exc_flags !== INF_FLAGS)
      $display("FAIL exc_inf got v=%b res=%h fl=%b required 1 7f800000 %b",
               result_valid, result, exc_flags, INF_FLAGS);
    else passed++;
    do_start();
    total++;
    if (exc_flags !== 2'b00)
      $display("FAIL exc_clear got fl=%b required 00", exc_flags);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_abort();
    test_reset_exec();
    test_saturate();
    test_exception();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
